// File: rtl/plateau_detector_ng_if.sv
// plateau_detector_ng_if: AXI-Stream bundle for the detector's sample input and trigger output
interface plateau_detector_ng_if #(parameter int DW = 32);
  logic [DW-1:0] tdata;
  logic tlast;
  logic tvalid;
  logic tready;
  modport master(output tdata, tlast, tvalid, input tready);
  modport slave(input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/plateau_detector_ng.sv
// plateau_detector_ng: windowed {phase, metric} averager with threshold validation, plateau tracking and fall trigger
module plateau_detector_ng #(
  parameter int WIDTH = 16,
  parameter int AVG_LEN_LOG2 = 5,
  parameter int PREAMBLE_LEN = 160,
  parameter int FALL_SHIFT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     threshold,
  input  logic [7:0]           validate_len,
  input  logic [15:0]          holdoff_len,
  plateau_detector_ng_if.slave  s_axis,
  plateau_detector_ng_if.master m_axis,
  output logic [31:0]          trigger_cnt,
  output logic [15:0]          abort_cnt
);
  localparam int L = 1 << AVG_LEN_LOG2;
  localparam int SW = WIDTH + AVG_LEN_LOG2;
  localparam int PW = AVG_LEN_LOG2 > 0 ? AVG_LEN_LOG2 : 1;
  typedef enum logic [1:0] {IDLE, VALIDATE, TRACK, HOLDOFF} state_t;
  logic flush, adv, ev;
  logic [WIDTH-1:0] in_m;
  logic signed [WIDTH-1:0] in_p;
  logic [WIDTH-1:0] win_m [L];
  logic signed [WIDTH-1:0] win_p [L];
  logic [PW-1:0] ptr;
  logic [SW-1:0] sum_m;
  logic signed [SW-1:0] sum_p;
  logic s1_valid, s1_last;
  logic out_valid, out_last;
  logic [2*WIDTH+15:0] out_data;
  state_t state, n_state;
  logic [7:0] run, n_run, vlen;
  logic [15:0] k, n_k, max_idx, n_max_idx, hcnt, n_hcnt;
  logic [WIDTH-1:0] max_val, n_max_val, avg_m, fall;
  logic signed [WIDTH-1:0] max_phase, n_max_phase, avg_p;
  logic exceed, upd, trig, abort;
  assign flush = reset | clear;
  assign adv = !out_valid | m_axis.tready;
  assign ev = s1_valid & adv;
  assign s_axis.tready = adv;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tlast = out_last;
  assign m_axis.tdata = out_data;
  assign in_m = s_axis.tdata[WIDTH-1:0];
  assign in_p = s_axis.tdata[2*WIDTH-1:WIDTH];
  // stage 1: sliding-window sums; the oldest sample is replaced in place
  always_ff @(posedge clk) begin
    if (flush) begin
      ptr <= '0;
      sum_m <= '0;
      sum_p <= '0;
      s1_valid <= 1'b0;
      s1_last <= 1'b0;
      for (int i = 0; i < L; i++) begin
        win_m[i] <= '0;
        win_p[i] <= '0;
      end
    end else if (adv) begin
      s1_valid <= s_axis.tvalid;
      s1_last <= s_axis.tlast;
      if (s_axis.tvalid) begin
        sum_m <= sum_m + SW'(in_m) - SW'(win_m[ptr]);
        sum_p <= sum_p + SW'(in_p) - SW'(win_p[ptr]);
        win_m[ptr] <= in_m;
        win_p[ptr] <= in_p;
        ptr <= (ptr == PW'(L - 1)) ? '0 : ptr + 1'b1;
      end
    end
  end
  assign avg_m = WIDTH'(sum_m >> AVG_LEN_LOG2);
  assign avg_p = WIDTH'(sum_p >>> AVG_LEN_LOG2);
  assign exceed = avg_m > threshold;
  assign vlen = (validate_len < 8'd2) ? 8'd2 : validate_len;
  assign fall = max_val - (max_val >> FALL_SHIFT);
  assign upd = avg_m > max_val;
  always_comb begin
    n_state = state;
    n_run = run;
    n_k = k;
    n_max_val = max_val;
    n_max_phase = max_phase;
    n_max_idx = max_idx;
    n_hcnt = hcnt;
    trig = 1'b0;
    abort = 1'b0;
    case (state)
      IDLE: begin
        n_run = exceed ? 8'd1 : 8'd0;
        n_k = '0;
        n_max_val = '0;
        n_max_phase = '0;
        n_max_idx = '0;
        n_state = exceed ? VALIDATE : IDLE;
      end
      VALIDATE: begin
        n_run = run + 8'd1;
        abort = s1_last;
        n_state = (s1_last | !exceed) ? IDLE : (run + 8'd1 == vlen) ? TRACK : VALIDATE;
      end
      TRACK: begin
        n_max_val = upd ? avg_m : max_val;
        n_max_phase = upd ? avg_p : max_phase;
        n_max_idx = upd ? k : max_idx;
        trig = avg_m < fall;
        abort = !trig & (s1_last | (k == 16'(PREAMBLE_LEN - 1)));
        n_k = k + 16'd1;
        n_hcnt = '0;
        n_state = trig ? HOLDOFF : abort ? IDLE : TRACK;
      end
      default: begin
        n_hcnt = hcnt + 16'd1;
        n_state = (s1_last | (holdoff_len != '0 && hcnt + 16'd1 >= holdoff_len)) ? IDLE : HOLDOFF;
      end
    endcase
  end
  // stage 2: FSM steps only on an evaluated sample; output regs hold while stalled
  always_ff @(posedge clk) begin
    if (flush) begin
      state <= IDLE;
      run <= '0;
      k <= '0;
      max_val <= '0;
      max_phase <= '0;
      max_idx <= '0;
      hcnt <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
    end else begin
      if (adv) begin
        out_valid <= s1_valid;
        out_last <= ev & trig;
        out_data <= (ev & trig) ? {n_max_val, k - n_max_idx, n_max_phase} : '0;
      end
      if (ev) begin
        state <= n_state;
        run <= n_run;
        k <= n_k;
        max_val <= n_max_val;
        max_phase <= n_max_phase;
        max_idx <= n_max_idx;
        hcnt <= n_hcnt;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      trigger_cnt <= '0;
      abort_cnt <= '0;
    end else if (ev & !clear) begin
      if (trig & ~&trigger_cnt) trigger_cnt <= trigger_cnt + 32'd1;
      if (abort & ~&abort_cnt) abort_cnt <= abort_cnt + 16'd1;
    end
  end
endmodule

// File: doc/plateau_detector_ng.md
# plateau_detector_ng

Next-generation preamble plateau detector for the OFDM receive chain. It sits after the delay-correlator metric and phase computation and before the coarse-CFO/timing blocks. It averages a joint {phase, metric} stream over a parametrised window, validates a threshold crossing, tracks the plateau maximum, and flags the sample where the metric falls to a programmable fraction of that maximum. Compared with the previous detector it adds:
- parametrised width, window and fall fraction
- runtime validate and holdoff lengths
- burst-end abort and `clear`
- trigger/abort statistics

## Interface
- `WIDTH`, 16: metric and phase sample width.
- `AVG_LEN_LOG2`, 5: averaging window L = 2^AVG_LEN_LOG2; legal range 0..8.
- `PREAMBLE_LEN`, 160: maximum number of TRACK samples before abort.
- `FALL_SHIFT`, 3: trigger level = max - (max >> FALL_SHIFT), i.e. 87.5% at the default.

- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `clear` in 1: synchronous; same effect as `reset` except the statistics counters are kept.
- `threshold` in WIDTH: unsigned detection threshold, sampled at every evaluation.
- `validate_len` in 8: number of consecutive samples above threshold required; values 0 and 1 are treated as 2.
- `holdoff_len` in 16: post-trigger holdoff in samples; 0 means wait for `i_tlast` only.
- `i_tdata` in 2*WIDTH: {phase (signed), metric (unsigned)}.
- `i_tlast` in 1: end of burst.
- `i_tvalid` in 1 / `i_tready` out 1: AXI-Stream input.
- `o_tdata` out 2*WIDTH+16: {max_val, offset[15:0], max_phase}; all zero on non-trigger beats.
- `o_tlast` out 1: trigger flag, high on exactly one beat per detection.
- `o_tvalid` out 1 / `o_tready` in 1: AXI-Stream output, one beat per input beat.
- `trigger_cnt` out 32: number of triggers, saturating.
- `abort_cnt` out 16: number of TRACK/VALIDATE aborts, saturating.

## Operation
- **Averager:** keeps running sums over the last L accepted samples. The window is zero-filled after reset/clear.
  - Sum width is WIDTH+AVG_LEN_LOG2.
  - avg_metric = sum >> AVG_LEN_LOG2 (logical shift).
  - avg_phase = sum >>> AVG_LEN_LOG2 (arithmetic shift). Truncate; no rounding.
- "Exceed" means avg_metric > threshold, strictly.
- The FSM advances once per accepted sample only.
- **IDLE:**
  - Clear run, k, max_val, max_phase and max_idx.
  - On exceed, go to VALIDATE with run=1.
- **VALIDATE:**
  - On exceed, run++. When the new run equals validate_len, go to TRACK.
  - On a non-exceed sample, go to IDLE.
- **TRACK:** k counts TRACK samples from 0.
  - fall = max_val - (max_val >> FALL_SHIFT), computed from max_val before this sample's update.
  - If avg_metric > max_val: max_val <= avg_metric, max_phase <= avg_phase, max_idx <= k.
  - If avg_metric < fall (strict): this sample's output beat has o_tlast=1 and o_tdata = {max_val, k - max_idx, max_phase}, using post-update values. Increment trigger_cnt and go to HOLDOFF.
  - Otherwise, if k == PREAMBLE_LEN-1: increment abort_cnt and go to IDLE.
- **HOLDOFF:** count samples.
  - Go to IDLE after holdoff_len samples, or on a sample with i_tlast=1, whichever comes first.
- **Burst end:** i_tlast=1 in VALIDATE or TRACK (when not triggering on that sample) increments abort_cnt and returns to IDLE.
- **Simultaneous events:** priority is trigger, then tlast-abort, then timeout. i_tlast on the trigger sample itself does not end holdoff.
- The statistics counters saturate at all-ones.

## Timing
- Two-stage pipeline: stage 1 updates the averager; stage 2 evaluates the FSM and registers the output.
- An accepted sample produces its output beat o_tvalid exactly 2 cycles later when o_tready is held high.
- Full throughput: one sample per cycle.
- Backpressure: i_tready = !stage2_valid | o_tready. The whole pipeline stalls when blocked; no beat is dropped or duplicated.
- o_tdata/o_tlast are stable while o_tvalid & !o_tready.
- Reset/clear values: o_tvalid=0, o_tlast=0, o_tdata=0, FSM in IDLE, sums and window zero; i_tready=1 the cycle after reset deasserts.
  - Reset also zeroes trigger_cnt and abort_cnt.
  - Reset or clear mid-burst discards in-flight beats, with no output for them.

## Test plan
- **Basic trigger:** L=1, threshold=100, validate_len=4; metric 0 for samples 0–9, 200 for 10–15, 400 at 16, 360 at 17, 340 at 18; phase = sample index -> VALIDATE at 10, TRACK from 14, o_tlast only on sample 18's beat with offset=2, max_phase=16, max_val=400; trigger_cnt=1.
- **Noise spike:** L=1, validate_len=4; metric 200 for 3 samples then 0 -> no trigger, abort_cnt unchanged, FSM back in IDLE.
- **Timeout:** L=1, PREAMBLE_LEN=160; metric held at 500 -> no trigger, abort_cnt=1 after the 160th TRACK sample; re-validation starts on the next exceed.
- **Averaging:** L=32 defaults; 32 samples of metric 1000, phase -64 -> avg_metric=1000 and avg_phase=-64 from the 32nd sample; with phase -1 held, avg_phase reaches -1 (arithmetic shift).
- **Holdoff and tlast:** holdoff_len=5 after a trigger -> a strong plateau within 5 samples is ignored. Separately, with holdoff_len=0, i_tlast ends holdoff. Separately, i_tlast during TRACK gives abort_cnt+1.
- **Backpressure:** random o_tready at 30% high with the basic-trigger stimulus -> output beat sequence identical to the unstalled run; reset asserted mid-TRACK -> all outputs zero and no trigger.
